// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
//   fetch_state_t   : fetch FSM states
//   decoded_instr_t : one prefetch queue entry (decoded fields plus fetch address)
//   decode_word()   : splits a 32-bit instruction word into its fields
package fetch_pkg;

    localparam logic [15:0] INSTR_BASE_DEFAULT = 16'h1000;
    localparam logic [7:0]  STOP_OP_DEFAULT    = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StStopped
    } fetch_state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dest;
        logic [7:0]  src1;
        logic [7:0]  src2;
        logic [15:0] pc;
    } decoded_instr_t;

    function automatic decoded_instr_t decode_word(input logic [31:0] word,
                                                   input logic [15:0] pc);
        decoded_instr_t d;
        d.opcode = word[31:24];
        d.dest   = word[23:16];
        d.src1   = word[15:8];
        d.src2   = word[7:0];
        d.pc     = pc;
        return d;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of decoded instructions.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, data_i    : write one entry (ignored when full unless a pop frees the slot)
//   pop_i             : remove the head entry (ignored when empty)
//   head_o            : current head entry, straight from registered storage
//   full_o, empty_o   : occupancy flags
//   count_o           : number of stored entries
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  decoded_instr_t         data_i,
    input  logic                   pop_i,
    output decoded_instr_t         head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    decoded_instr_t  mem_q [Depth];
    decoded_instr_t  mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full queue may still accept.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 32-bit words from instruction memory, decodes them
// and buffers them in a prefetch queue popped by Execution via valid/ready.
//   Clk, Reset            : clock, synchronous active-high reset
//   start                 : begin fetching at INSTR_BASE (only honoured when idle)
//   mem_addr, mem_nRead   : read request (nRead active low, one cycle per fetch)
//   mem_rdata             : read data, valid the cycle after the strobe, word in [31:0]
//   instr_valid/ready     : head-of-queue handshake
//   opcode/dest/src1/src2 : head instruction fields, instr_pc its fetch address
//   busy                  : fetching or queue not empty
//   done                  : one-cycle pulse when the STOP entry is popped
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] INSTR_BASE  = INSTR_BASE_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned DATA_W      = 256,
    parameter logic [7:0]  STOP_OP     = STOP_OP_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic [15:0]       mem_addr,
    output logic              mem_nRead,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode,
    output logic [7:0]        dest,
    output logic [7:0]        src1,
    output logic [7:0]        src2,
    output logic [15:0]       instr_pc,
    output logic              busy,
    output logic              done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count
`endif
);

    fetch_state_t   state_q, state_d;
    logic [15:0]    pc_q, pc_d;

    decoded_instr_t fetched;
    decoded_instr_t q_head;
    logic           q_full, q_empty;
    logic [$clog2(QUEUE_DEPTH):0] q_count;

    logic           issue;
    logic           push;
    logic           pop;
    logic           slot_free;

    assign fetched     = decode_word(mem_rdata[31:0], pc_q);
    assign instr_valid = !q_empty;
    assign pop         = instr_valid && instr_ready;
    // The head leaving this cycle makes room for the word arriving next cycle.
    assign slot_free   = !q_full || pop;

    fetch_queue #(
        .Depth (QUEUE_DEPTH)
    ) u_queue (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .data_i  (fetched),
        .pop_i   (pop),
        .head_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue   = 1'b0;
        push    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    pc_d    = INSTR_BASE;
                end
            end
            StReq: begin
                if (slot_free) begin
                    issue   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                push = 1'b1;
                if (fetched.opcode == STOP_OP) begin
                    state_d = StStopped;
                end else begin
                    pc_d    = pc_q + 16'd1;
                    state_d = StReq;
                end
            end
            StStopped: begin
                // STOP is always the last entry queued, so its pop ends the program.
                if (pop && (q_head.opcode == STOP_OP)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= INSTR_BASE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign mem_addr  = issue ? pc_q : 16'h0000;
    assign mem_nRead = !issue;

    assign opcode   = instr_valid ? q_head.opcode : 8'h00;
    assign dest     = instr_valid ? q_head.dest   : 8'h00;
    assign src1     = instr_valid ? q_head.src1   : 8'h00;
    assign src2     = instr_valid ? q_head.src2   : 8'h00;
    assign instr_pc = instr_valid ? q_head.pc     : 16'h0000;
    assign busy     = (state_q != StIdle) || !q_empty;

    logic unused_bits;
    assign unused_bits = ^{q_count, mem_rdata[DATA_W-1:32]};

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    assign stall = (state_q == StReq) && !slot_free;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StIdle) && start) begin
            fetch_cnt_d = 16'h0000;
            stall_cnt_d = 16'h0000;
        end else begin
            if (push && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned DataW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start;
    logic             ready;
    logic [15:0]      mem_addr;
    logic             mem_nread;
    logic [DataW-1:0] mem_rdata;
    logic             valid;
    logic [7:0]       opcode, dest, src1, src2;
    logic [15:0]      instr_pc;
    logic             busy, done;

    // Second instance: base address at the top of the address space.
    logic             b_start;
    logic             b_ready;
    logic [15:0]      b_addr;
    logic             b_nread;
    logic [DataW-1:0] b_rdata;
    logic             b_valid;
    logic [7:0]       b_opcode, b_dest, b_src1, b_src2;
    logic [15:0]      b_pc;
    logic             b_busy, b_done;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, stall_count, b_fetch_count, b_stall_count;
`endif

    instr_fetch_unit u_dut (
        .Clk         (clk),
        .Reset       (rst),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_nRead   (mem_nread),
        .mem_rdata   (mem_rdata),
        .instr_valid (valid),
        .instr_ready (ready),
        .opcode      (opcode),
        .dest        (dest),
        .src1        (src1),
        .src2        (src2),
        .instr_pc    (instr_pc),
        .busy        (busy),
        .done        (done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    instr_fetch_unit #(
        .INSTR_BASE (16'hFFFF)
    ) u_dut_wrap (
        .Clk         (clk),
        .Reset       (rst),
        .start       (b_start),
        .mem_addr    (b_addr),
        .mem_nRead   (b_nread),
        .mem_rdata   (b_rdata),
        .instr_valid (b_valid),
        .instr_ready (b_ready),
        .opcode      (b_opcode),
        .dest        (b_dest),
        .src1        (b_src1),
        .src2        (b_src2),
        .instr_pc    (b_pc),
        .busy        (b_busy),
        .done        (b_done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (b_fetch_count),
        .stall_count (b_stall_count)
`endif
    );

    bit [31:0]   imem [bit [15:0]];
    bit [31:0]   bmem [bit [15:0]];
    logic [47:0] exp_q[$];
    logic [15:0] rd_q[$];
    logic [47:0] b_exp_q[$];
    logic [15:0] b_rd_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          b_done_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] word_at(input bit is_b, input logic [15:0] a);
        if (is_b) return bmem.exists(a) ? bmem[a] : 32'h0;
        return imem.exists(a) ? imem[a] : 32'h0;
    endfunction

    // Memory models: data valid the cycle after the strobe; upper bits are filler.
    always @(posedge clk) begin
        if (!mem_nread) mem_rdata <= {{28{8'hA5}}, word_at(1'b0, mem_addr)};
        if (!b_nread)   b_rdata   <= {{28{8'h5A}}, word_at(1'b1, b_addr)};
    end

    task automatic add_instr(input logic [15:0] a, input logic [31:0] w);
        imem[a] = w;
        exp_q.push_back({w, a});
        rd_q.push_back(a);
    endtask

    task automatic add_b_instr(input logic [15:0] a, input logic [31:0] w);
        bmem[a] = w;
        b_exp_q.push_back({w, a});
        b_rd_q.push_back(a);
    endtask

    // Reads and pops are compared on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!mem_nread) begin
                check_eq("rd_pending", rd_q.size() != 0, 1'b1);
                if (rd_q.size() != 0) check_eq("rd_addr", mem_addr, rd_q.pop_front());
            end
            if (valid && ready) begin
                check_eq("pop_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    check_eq("head", {opcode, dest, src1, src2, instr_pc}, e);
                    check_eq("done_on_pop", done, e[47:40] == 8'hFF);
                end
            end else begin
                check_eq("done_no_pop", done, 1'b0);
            end
            if (done) done_cnt++;

            if (!b_nread) begin
                check_eq("b_rd_pending", b_rd_q.size() != 0, 1'b1);
                if (b_rd_q.size() != 0) check_eq("b_rd_addr", b_addr, b_rd_q.pop_front());
            end
            if (b_valid && b_ready) begin
                check_eq("b_pop_pending", b_exp_q.size() != 0, 1'b1);
                if (b_exp_q.size() != 0) begin
                    check_eq("b_head", {b_opcode, b_dest, b_src1, b_src2, b_pc},
                             b_exp_q.pop_front());
                end
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles, input bit rnd);
        for (int i = 0; i < max_cycles; i++) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            tick();
            if ((exp_q.size() == 0) && !busy) break;
        end
        ready = 1'b1;
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_exp_left"}, exp_q.size(), 0);
        check_eq({tag, "_rd_left"}, rd_q.size(), 0);
    endtask

    task automatic load_six_plus_stop();
        for (int i = 0; i < 6; i++) begin
            add_instr(16'h1000 + 16'(i),
                      {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)});
        end
        add_instr(16'h1006, 32'hFF00_0000);
    endtask

    initial begin
        int d0;
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b0;
        b_start = 1'b0;
        b_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_nread", mem_nread, 1'b1);
        check_eq("rst_addr", mem_addr, 16'h0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_head", {opcode, dest, src1, src2, instr_pc}, 48'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-instruction program ending in STOP.
        add_instr(16'h1000, 32'h0102_0304);
        add_instr(16'h1001, 32'hFF00_0000);
        ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        run_until_idle("t1", 40, 1'b0);
        check_eq("t1_done_cnt", done_cnt - d0, 1);

        // Backpressure: queue fills, fetch stalls, then random drain.
        load_six_plus_stop();
        ready = 1'b0;
        d0 = done_cnt;
        pulse_start();
        repeat (20) tick();
        check_eq("t2_valid", valid, 1'b1);
        check_eq("t2_head_pc", instr_pc, 16'h1000);
        check_eq("t2_reads_left", rd_q.size(), 3);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_stall_nread", mem_nread, 1'b1);
            tick();
        end
        run_until_idle("t2", 300, 1'b1);
        check_eq("t2_done_cnt", done_cnt - d0, 1);

        // Reset while in WAIT for the third fetch with two entries queued.
        load_six_plus_stop();
        ready = 1'b0;
        pulse_start();
        repeat (5) tick();
        check_eq("t4_pre_reads_left", rd_q.size(), 4);
        check_eq("t4_pre_valid", valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_valid", valid, 1'b0);
        check_eq("t4_nread", mem_nread, 1'b1);
        check_eq("t4_busy", busy, 1'b0);
        exp_q.delete();
        rd_q.delete();
        load_six_plus_stop();
        ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        run_until_idle("t4", 60, 1'b0);
        check_eq("t4_done_cnt", done_cnt - d0, 1);

        // Address wrap on the second instance.
        add_b_instr(16'hFFFF, 32'h1011_1213);
        add_b_instr(16'h0000, 32'hFF00_0000);
        b_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if ((b_exp_q.size() == 0) && !b_busy) break;
        end
        check_eq("wrap_busy", b_busy, 1'b0);
        check_eq("wrap_exp_left", b_exp_q.size(), 0);
        check_eq("wrap_done_cnt", b_done_cnt, 1);

`ifdef FETCH_PERF_CNT_EN
        add_instr(16'h1000, 32'h0501_0203);
        add_instr(16'h1001, 32'h0604_0506);
        add_instr(16'h1002, 32'hFF00_0000);
        ready = 1'b0;
        pulse_start();
        repeat (10) tick();
        check_eq("perf_fetch", fetch_count, 16'd3);
        check_eq("perf_stall", stall_count, 16'd0);
        run_until_idle("perf1", 40, 1'b0);
        add_instr(16'h1000, 32'h0501_0203);
        add_instr(16'h1001, 32'h0604_0506);
        add_instr(16'h1002, 32'hFF00_0000);
        check_eq("perf_fetch_kept", fetch_count, 16'd3);
        pulse_start();
        check_eq("perf_fetch_clr", fetch_count, 16'd0);
        check_eq("perf_stall_clr", stall_count, 16'd0);
        run_until_idle("perf2", 40, 1'b0);
        check_eq("perf_fetch_end", fetch_count, 16'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1);
    end

endmodule
